// File: rtl/io_ram.sv
// rtl/io_ram.sv - parametrised data RAM with switch input port, LED register and clearing sweep
module io_ram #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 8,
  localparam int AW            = $clog2(DEPTH),
  parameter int IN_ADDR        = 0,
  parameter int OUT_ADDR       = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             nw,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [WIDTH-1:0] Wdata_ram,
  input  logic [WIDTH-1:0] usr_input,
  output logic [WIDTH-1:0] Rdata1,
  output logic [WIDTH-1:0] Rdata2,
  output logic [WIDTH-1:0] LED,
  output logic             ready,
  output logic             in_changed
);

  localparam logic [AW-1:0] L_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] L_IN    = AW'(IN_ADDR);
  localparam logic [AW-1:0] L_OUT   = AW'(OUT_ADDR);
  localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_clr_ptr;
  logic [AW-1:0]    w_clr_ptr_nxt;
  logic             w_clr_we;
  logic             w_run_we;
  logic             w_addr1_ok;
  logic             r_ready;
  logic [WIDTH-1:0] r_led;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sync3;
  logic             r_in_changed;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // A write lands only on a real RAM word: inside the array and not the switch port.
  assign w_addr1_ok = ({1'b0, addr1} < L_DEPTH) && (addr1 != L_IN);
  assign w_run_we   = (r_state == S_RUN) && !nw && w_addr1_ok;

  // Next-state logic: walk the clear pointer over every word, then hand over to RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_clr_we      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (CLEAR_ON_RESET) begin
          w_clr_we = 1'b1;
          if (r_clr_ptr == L_LAST) begin
            w_state_nxt = S_RUN;
          end else begin
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // State register, clear pointer and ready flag; ready tracks entry into RUN.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_ready   <= (w_state_nxt == S_RUN);
    end
  end

  // Storage array: sweep writes zero, normal writes take the CPU data.
  always_ff @(posedge Clock) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_run_we) begin
      r_mem[addr1] <= Wdata_ram;
    end
  end

  // LED register mirrors every accepted write to the output address.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_led <= '0;
    end else if (w_run_we && (addr1 == L_OUT)) begin
      r_led <= Wdata_ram;
    end
  end

  // Switch synchroniser plus one extra stage used only for change detection.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= usr_input;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Change pulse, held off until the memory is usable.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_in_changed <= 1'b0;
    end else begin
      r_in_changed <= r_ready && (r_sync2 != r_sync3);
    end
  end

  // Combinational read ports; the switch address shadows the RAM word there.
  assign Rdata1 = !r_ready                    ? '0      :
                  (addr1 == L_IN)             ? r_sync2 :
                  ({1'b0, addr1} < L_DEPTH)   ? r_mem[addr1] : '0;
  assign Rdata2 = !r_ready                    ? '0      :
                  (addr2 == L_IN)             ? r_sync2 :
                  ({1'b0, addr2} < L_DEPTH)   ? r_mem[addr2] : '0;

  assign LED        = r_led;
  assign ready      = r_ready;
  assign in_changed = r_in_changed;

endmodule

// File: doc/io_ram.md
# io_ram

Parametrised data RAM with memory-mapped I/O for the pico_mips datapath. It is the successor to the fixed 5×8 data memory: width and depth are parameters, and it adds a synchronised read-only input port, a dedicated LED output register, a change-detect pulse and a post-reset clearing sweep. It exposes two asynchronous read ports and one synchronous write port (shared with read port 1). It sits between the CPU datapath and the board switches and LEDs.

## Interface
- WIDTH, 8: data word width in bits
- DEPTH, 8: number of addressable words (≥ 4)
- AW, $clog2(DEPTH): address width (derived, not overridden)
- IN_ADDR, 0: address of read-only switch input port
- OUT_ADDR, 3: address whose writes drive LED
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = skip sweep

- Clock  input  1  system clock, rising edge
- nReset  input  1  asynchronous, active-low reset
- nw  input  1  write enable, active low
- addr1  input  AW  write address / read port 1 address
- addr2  input  AW  read port 2 address
- Wdata_ram  input  WIDTH  write data
- usr_input  input  WIDTH  asynchronous switch input
- Rdata1  output  WIDTH  read data at addr1
- Rdata2  output  WIDTH  read data at addr2
- LED  output  WIDTH  LED register
- ready  output  1  high once memory is usable
- in_changed  output  1  one-cycle pulse when synchronised input changes

## Operation
- States: CLEAR, RUN. Reset forces CLEAR (or RUN-pending when CLEAR_ON_RESET=0), clr_ptr=0, ready=0, LED=0, in_changed=0, sync1/sync2/sync3=0.
- CLEAR: on each edge, writes 0 to mem[clr_ptr], then clr_ptr++. The edge that clears word DEPTH-1 moves to RUN and sets ready=1.
- CLEAR_ON_RESET=0: first edge after release moves to RUN and sets ready=1. Memory content is then undefined.
- While ready=0: nw is ignored, Rdata1/Rdata2 read 0, LED holds 0.
- RUN write: when nw=0, addr1<DEPTH and addr1≠IN_ADDR, mem[addr1] ← Wdata_ram on the edge. If addr1=OUT_ADDR, LED ← Wdata_ram on the same edge.
- Writes to IN_ADDR are silently discarded.
- Writes to addr1 ≥ DEPTH are silently discarded.
- Reads are combinational:
  - addr = IN_ADDR → sync2
  - addr ≥ DEPTH → 0
  - otherwise → mem[addr]
- Both read ports may target the same address. No write-to-read bypass: a same-cycle read returns the pre-edge value.
- Input path: sync1 ← usr_input, sync2 ← sync1, sync3 ← sync2 every edge, in all states.
- in_changed = registered (sync2 ≠ sync3). It is suppressed to 0 while ready=0.
- Reset asserted mid-sweep or mid-run: all state returns to reset values immediately. The sweep restarts from word 0 after release.

## Timing
- Clear latency: ready rises after edge DEPTH following reset release (DEPTH=8 → edge 8). The first accepted write is on edge DEPTH+1.
- Write latency: 1 edge. Data is visible on Rdata and LED right after the write edge.
- Read latency: 0 cycles (combinational from registers/array).
- usr_input to Rdata at IN_ADDR: 2 edges.
- usr_input to in_changed high: 3 edges. The pulse lasts exactly 1 cycle per change.
- An input toggling every cycle gives in_changed high every cycle (one pulse per change).
- Reset values: Rdata1=0, Rdata2=0 (ready=0); LED=0; ready=0; in_changed=0.

## Test plan
- **Reset sweep:** DEPTH=8. Release nReset, hold nw=0, addr1=5, Wdata_ram=0xAA during the sweep → ready low for edges 1–7 and high after edge 8. Rdata1 at addr 5 reads 0x00 (write ignored).
- **Write/read:** after ready, write 0x3C to addr 2 → next cycle Rdata1 and Rdata2 (both addr 2) read 0x3C. In the same cycle as the write, the read returns the old value 0x00.
- **LED and input port:**
  - Write 0x81 to addr 3 → LED=0x81 one edge later.
  - Write 0x55 to addr 0 → Rdata at addr 0 still shows synced usr_input, not 0x55.
- **Input sync and change:** usr_input 0x00→0xF0 → Rdata2 (addr 0) shows 0xF0 after edge 2. in_changed is high for exactly one cycle after edge 3.
- **Reset mid-sweep:** assert nReset after edge 4 of the sweep, re-release → ready rises only after 8 new edges. LED stays 0.
- **Parameter variant:** WIDTH=16, DEPTH=6, CLEAR_ON_RESET=0 → ready high after edge 1. Write to addr 7 is ignored, and reads at addr 7 return 0x0000.
